// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl -- multi-cycle RV32 control unit.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// FETCH and MEM wait on their memory handshakes; every other state lasts
// exactly one cycle. Outputs are decoded from the current state and the
// opcode captured at fetch time. While rst is high every output is forced
// to its idle value.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   imem_req  out  instruction fetch request (FETCH)
//   imem_ack  in   fetch data valid this cycle
//   instr     in   fetched instruction, captured on imem_req & imem_ack
//   br_taken  in   branch comparator result, latched in EXEC for branches
//   dmem_req  out  data request (MEM)
//   dmem_we   out  data write strobe (MEM, stores only)
//   dmem_ack  in   data access complete (only looked at in MEM)
//   ir_we     out  instruction register load (FETCH with ack)
//   op1_sel   out  operand-1 select: 0 = RS1, 1 = PC, 2 = zero-ext imm
//   rf_we     out  register file write (WB)
//   pc_we     out  PC update (WB)
//   pc_jump   out  PC source while pc_we: 1 = target, 0 = PC+4
//   illegal   out  one-cycle pulse in DECODE on an unsupported opcode
//   instret   out  retired-instruction counter, wraps
//   busy      out  low only in FETCH while waiting for imem_ack
module riscv_mc_ctrl #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  input  logic                   imem_ack,
  input  logic [31:0]            instr,
  input  logic                   br_taken,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  output logic                   ir_we,
  output logic [1:0]             op1_sel,
  output logic                   rf_we,
  output logic                   pc_we,
  output logic                   pc_jump,
  output logic                   illegal,
  output logic [WORD_LENGTH-1:0] instret,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    OP1_RS1 = 2'd0,
    OP1_PC  = 2'd1,
    OP1_IMZ = 2'd2
  } op1_sel_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t                 r_state;
  state_t                 w_next;
  op1_sel_t               r_op1_sel;
  logic [6:0]             r_opcode;
  logic [4:0]             r_rd;
  logic                   r_funct3_2;
  logic                   r_br_taken;
  logic [WORD_LENGTH-1:0] r_instret;

  // Only the fields the controller decodes are kept from the fetched word.
  logic                   w_unused_instr;
  assign w_unused_instr = ^{instr[31:15], instr[13:12]};

  logic     w_fetch_done;
  logic     w_legal;
  logic     w_is_mem;
  logic     w_is_store;
  logic     w_is_branch;
  logic     w_is_jump;
  logic     w_writes_rd;
  op1_sel_t w_op1_dec;

  assign w_fetch_done = (r_state == S_FETCH) && imem_ack;

  // Opcode classification of the captured instruction.
  always_comb begin
    w_legal     = 1'b1;
    w_is_mem    = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_writes_rd = 1'b0;
    w_op1_dec   = OP1_RS1;
    unique case (r_opcode)
      OPC_LOAD: begin
        w_is_mem    = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_STORE: begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b1;
      end
      OPC_OP, OPC_OPIMM, OPC_LUI: begin
        w_writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        w_writes_rd = 1'b1;
        w_op1_dec   = OP1_PC;
      end
      OPC_JAL: begin
        w_writes_rd = 1'b1;
        w_is_jump   = 1'b1;
        w_op1_dec   = OP1_PC;
      end
      OPC_JALR: begin
        w_writes_rd = 1'b1;
        w_is_jump   = 1'b1;
      end
      OPC_BRANCH: begin
        w_is_branch = 1'b1;
        w_op1_dec   = OP1_PC;
      end
      OPC_SYSTEM: begin
        w_writes_rd = 1'b1;
        // funct3[2] marks the CSR immediate forms (zimm in the rs1 field).
        if (r_funct3_2) begin
          w_op1_dec = OP1_IMZ;
        end
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_op1_sel  <= OP1_RS1;
      r_opcode   <= '0;
      r_rd       <= '0;
      r_funct3_2 <= 1'b0;
      r_br_taken <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_state <= w_next;
      if (w_fetch_done) begin
        r_opcode   <= instr[6:0];
        r_rd       <= instr[11:7];
        r_funct3_2 <= instr[14];
      end
      if (r_state == S_DECODE) begin
        r_op1_sel <= w_op1_dec;
      end
      if ((r_state == S_EXEC) && w_is_branch) begin
        r_br_taken <= br_taken;
      end
      if (r_state == S_WB) begin
        r_instret <= r_instret + WORD_LENGTH'(1);
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_jump  = 1'b0;
    illegal  = 1'b0;
    busy     = 1'b1;
    unique case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = imem_ack;
        if (imem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_EXEC: begin
        w_next = w_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        if (dmem_ack) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        pc_jump = w_is_jump || (w_is_branch && r_br_taken);
        rf_we   = w_writes_rd && (r_rd != 5'd0);
        w_next  = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    // Reset overrides everything so no handshake or write leaks through
    // in the cycle rst is raised.
    if (rst) begin
      w_next   = S_FETCH;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_jump  = 1'b0;
      illegal  = 1'b0;
      busy     = 1'b0;
    end
  end

  assign op1_sel = rst ? OP1_RS1 : r_op1_sel;
  assign instret = rst ? '0 : r_instret;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed testbench for riscv_mc_ctrl. A narrow instret width is used so the
// counter wrap can be reached by retiring instructions.
module tb_riscv_mc_ctrl;

  localparam int unsigned WL = 4;

  localparam logic [1:0] E_RS1 = 2'd0;
  localparam logic [1:0] E_PC  = 2'd1;
  localparam logic [1:0] E_IMZ = 2'd2;

  logic          clk;
  logic          rst;
  logic          imem_req;
  logic          imem_ack;
  logic [31:0]   instr;
  logic          br_taken;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack;
  logic          ir_we;
  logic [1:0]    op1_sel;
  logic          rf_we;
  logic          pc_we;
  logic          pc_jump;
  logic          illegal;
  logic [WL-1:0] instret;
  logic          busy;

  int unsigned   n_checks = 0;
  int unsigned   n_errs   = 0;
  logic [WL-1:0] exp_ret  = '0;

  riscv_mc_ctrl #(.WORD_LENGTH(WL)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .instr    (instr),
    .br_taken (br_taken),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .dmem_ack (dmem_ack),
    .ir_we    (ir_we),
    .op1_sel  (op1_sel),
    .rf_we    (rf_we),
    .pc_we    (pc_we),
    .pc_jump  (pc_jump),
    .illegal  (illegal),
    .instret  (instret),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one legal instruction with zero-wait fetch. mem: 0 none, 1 load,
  // 2 store; wait_n extra MEM cycles before dmem_ack. Branch input is brt in
  // EXEC and inverted afterwards. Entered and left at negedge+1 in FETCH.
  task automatic run_instr(input string name, input logic [31:0] ins,
                           input logic [1:0] e_op1, input int mem, input int wait_n,
                           input logic brt, input logic e_rf, input logic e_jump);
    @(negedge clk); imem_ack = 1'b1; instr = ins; #1;
    check({name, ".ir_we"}, 32'(ir_we), 32'd1);
    check({name, ".imem_req"}, 32'(imem_req), 32'd1);
    @(negedge clk); imem_ack = 1'b0; instr = '0; #1;
    check({name, ".dec_ir_we"}, 32'(ir_we), 32'd0);
    check({name, ".dec_illegal"}, 32'(illegal), 32'd0);
    check({name, ".dec_busy"}, 32'(busy), 32'd1);
    @(negedge clk); br_taken = brt; dmem_ack = (mem == 0); #1;
    check({name, ".ex_op1"}, 32'(op1_sel), 32'(e_op1));
    check({name, ".ex_pc_we"}, 32'(pc_we), 32'd0);
    check({name, ".ex_dmem_req"}, 32'(dmem_req), 32'd0);
    if (mem != 0) begin
      for (int k = 0; k <= wait_n; k++) begin
        @(negedge clk); br_taken = ~brt; dmem_ack = (k == wait_n); #1;
        check({name, ".mem_req"}, 32'(dmem_req), 32'd1);
        check({name, ".mem_we"}, 32'(dmem_we), 32'(mem == 2));
        check({name, ".mem_pc_we"}, 32'(pc_we), 32'd0);
      end
    end
    @(negedge clk); dmem_ack = 1'b0; br_taken = ~brt; #1;
    check({name, ".wb_pc_we"}, 32'(pc_we), 32'd1);
    check({name, ".wb_pc_jump"}, 32'(pc_jump), 32'(e_jump));
    check({name, ".wb_rf_we"}, 32'(rf_we), 32'(e_rf));
    check({name, ".wb_dmem_req"}, 32'(dmem_req), 32'd0);
    check({name, ".wb_instret"}, 32'(instret), 32'(exp_ret));
    exp_ret = exp_ret + 1'b1;
    @(negedge clk); br_taken = 1'b0; #1;
    check({name, ".next_imem_req"}, 32'(imem_req), 32'd1);
    check({name, ".next_busy"}, 32'(busy), 32'd0);
    check({name, ".instret"}, 32'(instret), 32'(exp_ret));
    check({name, ".op1_hold"}, 32'(op1_sel), 32'(e_op1));
  endtask

  task automatic run_illegal(input logic [31:0] ins);
    @(negedge clk); imem_ack = 1'b1; instr = ins; #1;
    check("ill.ir_we", 32'(ir_we), 32'd1);
    @(negedge clk); imem_ack = 1'b0; instr = '0; #1;
    check("ill.pulse", 32'(illegal), 32'd1);
    check("ill.pc_we", 32'(pc_we), 32'd0);
    check("ill.rf_we", 32'(rf_we), 32'd0);
    @(negedge clk); #1;
    check("ill.pulse_end", 32'(illegal), 32'd0);
    check("ill.imem_req", 32'(imem_req), 32'd1);
    check("ill.instret", 32'(instret), 32'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    instr    = 32'h003100B3;
    br_taken = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst.imem_req", 32'(imem_req), 32'd0);
    check("rst.ir_we", 32'(ir_we), 32'd0);
    check("rst.dmem_req", 32'(dmem_req), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.op1_sel", 32'(op1_sel), 32'(E_RS1));
    check("rst.instret", 32'(instret), 32'd0);

    @(negedge clk); rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; instr = '0; #1;
    check("rel.imem_req", 32'(imem_req), 32'd1);
    check("rel.busy", 32'(busy), 32'd0);

    // Reset in the middle of a stalled store.
    @(negedge clk); imem_ack = 1'b1; instr = 32'h0020A023; #1;
    @(negedge clk); imem_ack = 1'b0; instr = '0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rstmem.dmem_req", 32'(dmem_req), 32'd1);
    check("rstmem.dmem_we", 32'(dmem_we), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rstmem.drop_req", 32'(dmem_req), 32'd0);
    check("rstmem.pc_we", 32'(pc_we), 32'd0);
    check("rstmem.instret", 32'(instret), 32'd0);
    check("rstmem.imem_req", 32'(imem_req), 32'd1);
    @(negedge clk); dmem_ack = 1'b1; #1;
    check("rstmem.ack_ignored", 32'(dmem_req), 32'd0);
    check("rstmem.still_fetch", 32'(imem_req), 32'd1);
    @(negedge clk); dmem_ack = 1'b0;

    //        name      instr         op1    mem wait brt  rf    jump
    run_instr("add",    32'h003100B3, E_RS1, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr("auipc",  32'h00000297, E_PC,  0, 0, 1'b0, 1'b1, 1'b0);
    run_instr("csrrwi", 32'h3002D073, E_IMZ, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("sw",     32'h0020A023, E_RS1, 2, 3, 1'b0, 1'b0, 1'b0);
    run_instr("lw",     32'h0000A203, E_RS1, 1, 0, 1'b0, 1'b1, 1'b0);
    run_instr("beq_t",  32'h00208463, E_PC,  0, 0, 1'b1, 1'b0, 1'b1);
    run_instr("beq_nt", 32'h00208463, E_PC,  0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("jal",    32'h008000EF, E_PC,  0, 0, 1'b0, 1'b1, 1'b1);
    run_instr("jalr",   32'h00008067, E_RS1, 0, 0, 1'b0, 1'b0, 1'b1);
    run_instr("lui",    32'h123452B7, E_RS1, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr("nop",    32'h00000013, E_RS1, 0, 0, 1'b1, 1'b0, 1'b0);
    run_illegal(32'h0000007F);

    // Retire up to all-ones, then one more to wrap.
    while (exp_ret != '1) begin
      run_instr("fill", 32'h003100B3, E_RS1, 0, 0, 1'b0, 1'b1, 1'b0);
    end
    run_instr("wrap", 32'h003100B3, E_RS1, 0, 0, 1'b0, 1'b1, 1'b0);
    check("wrap.instret_zero", 32'(instret), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
